// File: rtl/vga_frame_ctrl_if.sv
// rtl/vga_frame_ctrl_if.sv - host update handshake bundle for the VGA frame controller
interface vga_frame_ctrl_if;
  logic [15:0] upd_value;
  logic        upd_valid;
  logic        upd_ready;

  modport master (output upd_value, output upd_valid, input upd_ready);
  modport slave  (input upd_value, input upd_valid, output upd_ready);
endinterface

// File: rtl/vga_frame_ctrl.sv
// rtl/vga_frame_ctrl.sv - 640x480 VGA timing generator with tear-free displayed-value register
module vga_frame_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic               CLK100MHZ,
  input  logic               rst,
  vga_frame_ctrl_if.slave    upd,
  output logic [15:0]        disp_value,
  output logic               pix_tick,
  output logic [9:0]         hcount,
  output logic [9:0]         vcount,
  output logic               video_on,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    hcount_q, hcount_d, vcount_q, vcount_d;
  logic          pix_tick_q, pix_tick_d;
  logic          video_on_q, video_on_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          frame_start_q, frame_start_d;
  logic [15:0]   shadow_q, shadow_d, disp_q, disp_d;
  logic          ready_q, ready_d;
  logic          tick, h_last, v_last, commit;

  always_comb begin
    tick   = (div_q == DW'(CLK_DIV - 1));
    h_last = (hcount_q == 10'(H_TOTAL - 1));
    v_last = (vcount_q == 10'(V_TOTAL - 1));
    // Commit on the tick that moves the counters into (0, V_ACTIVE): first blanking line.
    commit = tick && h_last && (vcount_q == 10'(V_ACTIVE - 1));

    div_d    = tick ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      hcount_d = h_last ? 10'd0 : hcount_q + 10'd1;
      if (h_last) begin
        vcount_d = v_last ? 10'd0 : vcount_q + 10'd1;
      end
    end

    // Decode from next-count values so the registered flags line up with the counters.
    pix_tick_d    = (div_d == DW'(CLK_DIV - 1));
    video_on_d    = (hcount_d < 10'(H_ACTIVE)) && (vcount_d < 10'(V_ACTIVE));
    hs_d          = !((hcount_d >= 10'(H_ACTIVE + H_FP)) &&
                      (hcount_d <  10'(H_ACTIVE + H_FP + H_SYNC)));
    vs_d          = !((vcount_d >= 10'(V_ACTIVE + V_FP)) &&
                      (vcount_d <  10'(V_ACTIVE + V_FP + V_SYNC)));
    frame_start_d = tick && h_last && v_last;

    state_d  = state_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    ready_d  = ready_q;
    case (state_q)
      IDLE: begin
        if (upd.upd_valid && ready_q) begin
          shadow_d = upd.upd_value;
          state_d  = PENDING;
          ready_d  = 1'b0;
        end
      end
      PENDING: begin
        if (commit) begin
          disp_d  = shadow_q;
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      pix_tick_q    <= 1'b0;
      video_on_q    <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
      shadow_q      <= 16'h0000;
      disp_q        <= 16'h0000;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      pix_tick_q    <= pix_tick_d;
      video_on_q    <= video_on_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
      shadow_q      <= shadow_d;
      disp_q        <= disp_d;
      ready_q       <= ready_d;
    end
  end

  assign upd.upd_ready = ready_q;
  assign disp_value    = disp_q;
  assign pix_tick      = pix_tick_q;
  assign hcount        = hcount_q;
  assign vcount        = vcount_q;
  assign video_on      = video_on_q;
  assign VGA_HS        = hs_q;
  assign VGA_VS        = vs_q;
  assign frame_start   = frame_start_q;

endmodule

// File: doc/vga_frame_ctrl.md
Name: vga_frame_ctrl

Overview:
- Sequencing controller for the VGA display path. Divides CLK100MHZ into a pixel-rate enable and runs the 640x480@60 horizontal/vertical timing counters.
- Generates VGA_HS/VGA_VS, pixel coordinates and the active-video flag for the pixel/glyph renderer.
- Owns the 16-bit displayed value register. Host updates go through a valid/ready handshake and are committed only at the start of vertical blanking, so a frame never shows a torn value.

Parameters:
- CLK_DIV, 4, CLK100MHZ cycles per pixel (>=2).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- Derived: H_TOTAL = 800 and V_TOTAL = 525, each required <= 1024.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- upd_value  in  16  new value to display
- upd_valid  in  1  upd_value is valid; source holds value and valid until accepted
- upd_ready  out  1  controller can accept an update
- disp_value  out  16  value the renderer must use for the current frame
- pix_tick  out  1  one-CLK pulse per pixel period
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- video_on  out  1  hcount<H_ACTIVE && vcount<V_ACTIVE
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- frame_start  out  1  one-CLK pulse when counters enter (0,0)

Behaviour:
- Reset (rst=0, async) sets:
  - divider=0, hcount=0, vcount=0, pix_tick=0, frame_start=0.
  - video_on=0, VGA_HS=1, VGA_VS=1.
  - disp_value=16'h0000; shadow register=0; state=IDLE, so upd_ready=1.
- Reset release is sampled on the clock; the first CLK100MHZ edge with rst=1 begins counting.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_tick=1 for exactly the one cycle in which divider==CLK_DIV-1; the counters advance on that edge.
- hcount advances on pix_tick. At H_TOTAL-1 it wraps to 0 and vcount advances. vcount wraps from V_TOTAL-1 to 0.
- VGA_HS, VGA_VS and video_on are registered, decoded from next-count values, so they stay aligned with hcount/vcount on every cycle. No combinational glitches.
  - VGA_HS=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
  - VGA_VS=0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults).
- frame_start=1 for the single CLK cycle following the edge where the counters wrap (799,524)->(0,0). It is not asserted on reset release.
- Update FSM, states IDLE and PENDING:
  - IDLE: upd_ready=1. When upd_valid&&upd_ready, capture upd_value into the shadow register and go to PENDING.
  - PENDING: upd_ready=0; upd_valid is ignored.
  - Commit edge = the pix_tick edge where counters move to (hcount=0, vcount=V_ACTIVE), i.e. the start of vertical blanking.
  - On the commit edge: disp_value<=shadow, state<=IDLE. upd_ready returns to 1 on the following cycle.
- disp_value changes only on a commit edge or on reset. It is constant throughout every active region.
- Acceptance on the commit edge itself: only possible from IDLE. The value goes to the shadow and commits at the next frame's blanking; there is no same-frame bypass.
- Update accepted during blanking (vcount>=480): commits at the next frame's vcount=480. The value becomes visible one frame later than it would have if accepted before the commit edge.
- Reset mid-operation: a pending update is discarded; disp_value=0; timing restarts at (0,0).

Test Plan:
- Timing, default parameters:
  - pix_tick period is 4 CLK.
  - Line period is 3200 CLK; frame period is 1,680,000 CLK; frame_start spacing is 1,680,000 CLK.
- Sync and active-video decode:
  - VGA_HS low for 384 CLK, starting when hcount=656.
  - VGA_VS low for 6400 CLK, covering lines 490-491.
  - video_on high for 640 pixels x 480 lines, and 0 at (640,0) and at (0,480).
- Tear-free update:
  - Stimulus: after reset, at vcount=100 assert upd_valid with upd_value=16'h03bc.
  - Response: accepted within 1 CLK; upd_ready=0.
  - disp_value stays 16'h0000 through line 479 and becomes 16'h03bc exactly on the tick into (0,480).
  - upd_ready=1 on the next cycle.
- Backpressure:
  - Stimulus: while PENDING, drive upd_value=16'h5e60 with upd_valid=1.
  - Response: not accepted and disp_value unaffected. Accepted on the first cycle after commit; commits one frame later.
- Update accepted in blanking:
  - Stimulus: upd_value=16'ha53f accepted at vcount=500.
  - Response: disp_value is unchanged through the next whole active frame and updates at the following vcount=480.
- Reset mid-frame:
  - Stimulus: rst=0 at vcount=200 with an update pending.
  - Response: all outputs go to reset values immediately (asynchronous), upd_ready=1, and timing restarts from (0,0) after release.
